// File: rtl/chunked_add_sequencer_if.sv
// Start/busy/done handshake and operand/result bus for chunked_add_sequencer.
// The width follows NCHUNK: each chunk is 6 bits.
interface chunked_add_sequencer_if #(
    parameter int NCHUNK = 4
);
    localparam int W = 6 * NCHUNK;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    modport master (
        output start, a, b, cin, op_sub,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, op_sub,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/chunked_add_sequencer.sv
// Wide adder that reuses one 6-bit carry-lookahead adder, one chunk per clock, LSB chunk first.
// Optional macro CHUNK_ADD_SUB_EN adds the subtract path (b inverted, carry-in forced to 1).
module carry_look_ahead_adder_cin_cout_6 (
    input  logic [5:0] i_a,
    input  logic [5:0] i_b,
    input  logic       i_cin,
    output logic [5:0] o_sum,
    output logic       o_cout
);
    logic [5:0] w_g;
    logic [5:0] w_p;
    logic [6:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is a flat sum of products of generate/propagate terms, not a ripple chain.
    always_comb begin
        logic term;
        logic acc;
        w_c = '0;
        w_c[0] = i_cin;
        for (int i = 1; i <= 6; i++) begin
            term = i_cin;
            for (int k = 0; k < i; k++) begin
                term = term & w_p[k];
            end
            acc = term;
            for (int j = 0; j < i; j++) begin
                term = w_g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & w_p[k];
                end
                acc = acc | term;
            end
            w_c[i] = acc;
        end
    end

    assign o_sum  = w_p ^ w_c[5:0];
    assign o_cout = w_c[6];
endmodule

module chunked_add_sequencer #(
    parameter int NCHUNK = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    chunked_add_sequencer_if.slave   bus
);
    localparam int W  = 6 * NCHUNK;
    localparam int IW = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic            r_cout;
    logic            r_ovf;

    logic            w_accept;
    logic            w_last;
    logic [W-1:0]    w_b_eff;
    logic            w_carry_init;
    logic [5:0]      w_a_chunk;
    logic [5:0]      w_b_chunk;
    logic [5:0]      w_sum;
    logic            w_chunk_cout;
    logic            w_ovf_top;
    logic [W-1:0]    w_result;

`ifdef CHUNK_ADD_SUB_EN
    assign w_b_eff      = bus.op_sub ? ~bus.b : bus.b;
    assign w_carry_init = bus.op_sub ? 1'b1 : bus.cin;
`else
    assign w_b_eff      = bus.b;
    assign w_carry_init = bus.cin;
`endif

    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_last   = (r_idx == IW'(NCHUNK - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_chunk = r_a[6*i +: 6];
                w_b_chunk = r_b[6*i +: 6];
            end
        end
    end

    carry_look_ahead_adder_cin_cout_6 u_cla (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_chunk_cout)
    );

    // Only meaningful on the top chunk: w_sum[5] is then the result sign bit.
    assign w_ovf_top = (r_a[W-1] == r_b[W-1]) && (w_sum[5] != r_a[W-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_eff;
            r_carry <= w_carry_init;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_carry <= w_chunk_cout;
            if (w_last) begin
                r_cout <= w_chunk_cout;
                r_ovf  <= w_ovf_top;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            logic [5:0] r_chunk;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_chunk <= '0;
                end else if ((r_state == S_RUN) && (r_idx == IW'(gi))) begin
                    r_chunk <= w_sum;
                end
            end

            assign w_result[6*gi +: 6] = r_chunk;
        end
    endgenerate

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.result   = w_result;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Bench for chunked_add_sequencer: an arithmetic reference model checked every cycle,
// plus directed operations with hand-computed literal results.
module tb_chunked_add_sequencer;
    localparam int NCHUNK = 4;
    localparam int W      = 6 * NCHUNK;
`ifdef CHUNK_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chunked_add_sequencer_if #(.NCHUNK(NCHUNK)) bus ();

    chunked_add_sequencer #(.NCHUNK(NCHUNK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns {overflow, cout, sum} computed with plain wide arithmetic.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sub);
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   s;
        logic         ovf;
        be  = (SUB_EN && sub) ? ~b : b;
        c0  = (SUB_EN && sub) ? 1'b1 : cin;
        s   = {1'b0, a} + {1'b0, be} + (W+1)'(c0);
        ovf = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, s};
    endfunction

    // Reference model: cycles remaining, done pulse and held result.
    int           m_cnt;
    logic         m_done;
    logic [W-1:0] m_res;
    logic         m_cout;
    logic         m_ovf;
    logic [W+1:0] p_val;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            p_val  <= '0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_res  <= p_val[W-1:0];
                m_cout <= p_val[W];
                m_ovf  <= p_val[W+1];
            end
        end else if (bus.start) begin
            m_cnt  <= NCHUNK;
            m_done <= 1'b0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            p_val  <= model_op(bus.a, bus.b, bus.cin, bus.op_sub);
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(m_cnt > 0));
        check("done", 32'(bus.done), 32'(m_done));
        if (m_cnt == 0) begin
            check("result", 32'(bus.result), 32'(m_res));
            check("cout", 32'(bus.cout), 32'(m_cout));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
        end else begin
            check("cout_clr", 32'(bus.cout), 32'(1'b0));
            check("ovf_clr", 32'(bus.overflow), 32'(1'b0));
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.op_sub = sub; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        wait_done(n);
        check({name, "_latency"}, 32'(n), 32'(NCHUNK));
        check({name, "_result"}, 32'(bus.result), 32'(er));
        check({name, "_cout"}, 32'(bus.cout), 32'(ec));
        check({name, "_ovf"}, 32'(bus.overflow), 32'(eo));
        $display("op %s a=%06h b=%06h cin=%0d sub=%0d -> result=%06h cout=%0d ovf=%0d",
                 name, a, b, cin, sub, bus.result, bus.cout, bus.overflow);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int dones;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op_sub = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(bus.busy), 32'(1'b0));
            check("idle_result", 32'(bus.result), 32'(0));
        end
        $display("op idle: 10 cycles with start low");

        run_op("carry6", 24'h00003F, 24'h000001, 1'b0, 1'b0, 24'h000040, 1'b0, 1'b0);
        run_op("wrap",   24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0);
        run_op("wrapcin",24'hFFFFFF, 24'h000001, 1'b1, 1'b0, 24'h000001, 1'b1, 1'b0);
        run_op("ovf",    24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1);
`ifdef CHUNK_ADD_SUB_EN
        run_op("sub",    24'h000005, 24'h000007, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0);
`else
        run_op("sub",    24'h000005, 24'h000007, 1'b0, 1'b1, 24'h00000C, 1'b0, 1'b0);
`endif

        // Reset while chunk 2 is being added.
        @(negedge clk);
        bus.a = 24'h0ABCDE; bus.b = 24'h012345; bus.cin = 1'b0; bus.op_sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'(1'b0));
        check("rst_done", 32'(bus.done), 32'(1'b0));
        check("rst_result", 32'(bus.result), 32'(0));
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'(0));
        $display("op reset mid-run: busy=%0d dones=%0d", bus.busy, dones);

        // start held through RUN with changing operands.
        @(negedge clk);
        bus.a = 24'h123456; bus.b = 24'h111111; bus.cin = 1'b0; bus.op_sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.done && n < 20) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            @(negedge clk);
            n++;
        end
        check("held_latency", 32'(n), 32'(NCHUNK));
        check("held_result", 32'(bus.result), 32'(24'h234567));
        check("held_cout", 32'(bus.cout), 32'(1'b0));
        check("held_ovf", 32'(bus.overflow), 32'(1'b0));
        $display("op held: result=%06h cout=%0d ovf=%0d", bus.result, bus.cout, bus.overflow);

        // start still high in DONE: back-to-back operation.
        bus.a = 24'h000FFF; bus.b = 24'h000001; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'(1'b1));
        wait_done(n);
        check("b2b_latency", 32'(n), 32'(NCHUNK));
        check("b2b_result", 32'(bus.result), 32'(24'h001000));
        check("b2b_cout", 32'(bus.cout), 32'(1'b0));
        $display("op back-to-back: result=%06h latency=%0d", bus.result, n);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
